traffic_phase_timer: RTL and testbench

//  Upstream pacing stage for the traffic light sequencer. It reads back the

---
 rtl/traffic_phase_timer.sv | 108 ++++++++++
 tb/tb_traffic_phase_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// Dwell timer and pedestrian latch that paces the traffic light sequencer from its own light feedback.
// Define TRAFFIC_PED_HOLD_EN to hold green after its minimum time until a pedestrian request arrives.
module traffic_phase_timer #(
  parameter int CNT_W       = 8,
  parameter int RED_TICKS   = 20,
  parameter int RA_TICKS    = 4,
  parameter int GREEN_TICKS = 20,
  parameter int AMBER_TICKS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic red,
  input  logic amber,
  input  logic green,
  input  logic ped_req,
  output logic step,
  output logic fault,
  output logic ped_pending,
  output logic ped_ack,
  output logic walk
);

  localparam logic [2:0] LT_RED   = 3'b100;
  localparam logic [2:0] LT_RA    = 3'b110;
  localparam logic [2:0] LT_GREEN = 3'b001;
  localparam logic [2:0] LT_AMBER = 3'b010;

  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] RA_LAST    = CNT_W'(RA_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] DWELL_MAX  = {CNT_W{1'b1}};

  logic [2:0]       lights;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] last;
  logic             legal;
  logic             is_red;
  logic             is_amber;
  logic             phase_done;

  assign lights = {red, amber, green};

  always_comb begin
    legal    = 1'b1;
    is_red   = 1'b0;
    is_amber = 1'b0;
    last     = RED_LAST;
    case (lights)
      LT_RED:   begin last = RED_LAST; is_red = 1'b1; end
      LT_RA:    last = RA_LAST;
      LT_GREEN: last = GREEN_LAST;
      LT_AMBER: begin last = AMBER_LAST; is_amber = 1'b1; end
      default:  legal = 1'b0;
    endcase
  end

  // A held green only releases once its minimum time is up and someone is waiting.
`ifdef TRAFFIC_PED_HOLD_EN
  always_comb begin
    if (lights == LT_GREEN)
      phase_done = (dwell >= GREEN_LAST) && (ped_pending || ped_req);
    else
      phase_done = (dwell == last);
  end
`else
  assign phase_done = (dwell == last);
`endif

  assign step  = !rst && (!legal || phase_done);
  assign fault = !rst && !legal;

  always_ff @(posedge clk) begin
    if (rst)
      dwell <= '0;
    else if (step)
      dwell <= '0;
`ifdef TRAFFIC_PED_HOLD_EN
    else if (lights == LT_GREEN && dwell >= GREEN_LAST)
      dwell <= GREEN_LAST;
`endif
    else if (dwell != DWELL_MAX)
      dwell <= dwell + 1'b1;
  end

  // Serving a request on the amber->red step overrides a request latched in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
      walk        <= 1'b0;
    end else begin
      ped_ack <= 1'b0;
      if (ped_req && !walk)
        ped_pending <= 1'b1;
      if (!legal) begin
        walk <= 1'b0;
      end else if (step && is_amber && (ped_pending || ped_req)) begin
        walk        <= 1'b1;
        ped_pending <= 1'b0;
        ped_ack     <= 1'b1;
      end else if (step && is_red) begin
        walk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomized self-checking bench: a light sequencer plus a timestamp-based reference model of the pacing rules.
// Follows TRAFFIC_PED_HOLD_EN the same way the design does.
module tb_traffic_phase_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic red = 1'b1, amber = 1'b1, green = 1'b1;
  logic ped_req = 1'b0;
  logic step, fault, ped_pending, ped_ack, walk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase start timestamps instead of a counter
  int         cyc = 0;
  int         start = 0;
  logic [2:0] m_lights = 3'b100;
  logic       m_pend = 1'b0, m_walk = 1'b0, m_ack = 1'b0;
  bit         m_valid = 1'b0;
  logic [2:0] illegal_set [4] = '{3'b000, 3'b011, 3'b101, 3'b111};

  traffic_phase_timer #(
    .CNT_W(8), .RED_TICKS(4), .RA_TICKS(2), .GREEN_TICKS(6), .AMBER_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .ped_req(ped_req),
    .step(step), .fault(fault), .ped_pending(ped_pending), .ped_ack(ped_ack), .walk(walk)
  );

  always #5 clk = ~clk;

  function automatic int ticks_of(input logic [2:0] l);
    case (l)
      3'b100:  return 4;
      3'b110:  return 2;
      3'b001:  return 6;
      3'b010:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] next_of(input logic [2:0] l);
    case (l)
      3'b100:  return 3'b110;
      3'b110:  return 3'b001;
      3'b001:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model past the rising edge.
  task automatic applyStimulus(input logic r, input logic req, input bit frc, input logic [2:0] fval);
    logic [2:0] seen;
    int         age;
    bit         lg;
    bit         hold_green;
    logic       exp_step, exp_fault, old_pend;
    @(negedge clk);
    seen = frc ? fval : m_lights;
    rst = r;
    ped_req = req;
    {red, amber, green} = seen;
    #1;
    lg = (ticks_of(seen) != 0);
    age = cyc - start;
    hold_green = 1'b0;
`ifdef TRAFFIC_PED_HOLD_EN
    hold_green = (seen == 3'b001);
`endif
    if (r) begin
      exp_step = 1'b0;
      exp_fault = 1'b0;
    end else if (!lg) begin
      exp_step = 1'b1;
      exp_fault = 1'b1;
    end else begin
      exp_fault = 1'b0;
      if (hold_green)
        exp_step = (age >= 5) && (m_pend || req);
      else
        exp_step = (age == ticks_of(seen) - 1);
    end
    checkOutput("step", step, exp_step);
    checkOutput("fault", fault, exp_fault);
    if (m_valid) begin
      checkOutput("walk", walk, m_walk);
      checkOutput("ped_pending", ped_pending, m_pend);
      checkOutput("ped_ack", ped_ack, m_ack);
    end
    if (r) begin
      m_valid = 1'b1;
      m_pend = 1'b0;
      m_walk = 1'b0;
      m_ack = 1'b0;
      start = cyc + 1;
    end else begin
      old_pend = m_pend;
      m_ack = 1'b0;
      if (req && !m_walk) m_pend = 1'b1;
      if (!lg) begin
        m_walk = 1'b0;
      end else if (exp_step && seen == 3'b010 && (old_pend || req)) begin
        m_walk = 1'b1;
        m_pend = 1'b0;
        m_ack = 1'b1;
      end else if (exp_step && seen == 3'b100) begin
        m_walk = 1'b0;
      end
      if (exp_step) begin
        start = cyc + 1;
        m_lights = lg ? next_of(seen) : 3'b100;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  // Idles until the model is about to present the given lights at the given phase age.
  task automatic runUntil(input logic [2:0] ph, input int age_target, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (m_lights == ph && (cyc - start) == age_target) return;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    end
    checkOutput(tag, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset with illegal lights present
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111);

    // Free-running cycles, no requests
    idle(32);

    // Request pulsed at green age 1, then watch it served into red
    runUntil(3'b001, 1, "wait_green1");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    idle(30);

    // Single illegal cycle, then the following red timing
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b101);
    idle(12);

    // Request in amber so walk is up, then reset mid-green
    runUntil(3'b010, 0, "wait_amber");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    runUntil(3'b001, 3, "wait_green3");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    idle(20);

    // Long quiet stretch: held green in hold builds, plain cycling otherwise
    idle(30);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
    idle(10);

    // Randomized mix of requests, illegal glitches and resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 79) == 0),
                    illegal_set[$urandom_range(0, 3)]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
